// File: rtl/lsu_exe.sv
// LSU execute stage: effective address, alignment check, one data-memory
// transaction with lane steering, and a registered writeback handoff.
module lsu_exe #(
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_DriveFromIssue_1,
   output logic             o_FreeToIssue_1,
   input  logic [3:0]       i_LsuOp_4,
   input  logic [4:0]       i_Rd_5,
   input  logic [TAG_W-1:0] i_Tag_TAG_W,
   input  logic [31:0]      i_OperandL_32,
   input  logic [31:0]      i_OperandR_32,
   input  logic [31:0]      i_Imm_32,
   output logic             o_MemReq_1,
   output logic             o_MemWe_1,
   output logic [31:0]      o_MemAddr_32,
   output logic [3:0]       o_MemBe_4,
   output logic [31:0]      o_MemWdata_32,
   input  logic             i_MemGnt_1,
   input  logic             i_MemRvalid_1,
   input  logic [31:0]      i_MemRdata_32,
   output logic             o_DriveToWriteBack_1,
   input  logic             i_FreeFromWriteBack_1,
   output logic [4:0]       o_WbRd_5,
   output logic             o_WbWe_1,
   output logic [31:0]      o_WbData_32,
   output logic [TAG_W-1:0] o_WbTag_TAG_W,
   output logic [1:0]       o_WbExc_2
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT - 1);

   state_t           state;
   logic [3:0]       op;
   logic [31:0]      addr;
   logic [15:0]      cnt;

   logic [31:0]      ea;
   logic             isStore;
   logic             misal;
   logic             tmo;
   logic [3:0]       stBe;
   logic [31:0]      stWdata;
   logic [31:0]      lane;
   logic [31:0]      ldData;

   assign o_FreeToIssue_1 = (state == IDLE) & ~rst;
   assign tmo = (cnt >= TMO);

   always_comb begin
      ea      = i_OperandL_32 + i_Imm_32;
      isStore = i_LsuOp_4[3];
      stBe    = 4'hF;
      stWdata = i_OperandR_32;
      misal   = 1'b0;
      unique case (1'b1)
         i_LsuOp_4[1:0] == 2'b00: begin
            stBe    = 4'b0001 << ea[1:0];
            stWdata = {4{i_OperandR_32[7:0]}};
         end
         i_LsuOp_4[1:0] == 2'b01: begin
            stBe    = ea[1] ? 4'b1100 : 4'b0011;
            stWdata = {2{i_OperandR_32[15:0]}};
            misal   = ea[0];
         end
         default: misal = |ea[1:0];
      endcase
   end

   // op[2] set means zero-extend, otherwise sign-extend sub-word loads
   always_comb begin
      lane   = i_MemRdata_32 >> {addr[1:0], 3'b000};
      ldData = lane;
      unique case (1'b1)
         op[1:0] == 2'b00: ldData = {{24{~op[2] & lane[7]}}, lane[7:0]};
         op[1:0] == 2'b01: ldData = {{16{~op[2] & lane[15]}}, lane[15:0]};
         default:          ldData = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         op                   <= '0;
         addr                 <= '0;
         cnt                  <= '0;
         o_MemReq_1           <= 1'b0;
         o_MemWe_1            <= 1'b0;
         o_MemAddr_32         <= '0;
         o_MemBe_4            <= '0;
         o_MemWdata_32        <= '0;
         o_DriveToWriteBack_1 <= 1'b0;
         o_WbRd_5             <= '0;
         o_WbWe_1             <= 1'b0;
         o_WbData_32          <= '0;
         o_WbTag_TAG_W        <= '0;
         o_WbExc_2            <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_DriveFromIssue_1) begin
                  op            <= i_LsuOp_4;
                  addr          <= ea;
                  cnt           <= '0;
                  o_WbRd_5      <= i_Rd_5;
                  o_WbTag_TAG_W <= i_Tag_TAG_W;
                  if (misal) begin
                     state                <= WB;
                     o_DriveToWriteBack_1 <= 1'b1;
                     o_WbWe_1             <= 1'b0;
                     o_WbData_32          <= ea;
                     o_WbExc_2            <= isStore ? 2'b10 : 2'b01;
                  end else begin
                     state         <= REQ;
                     o_MemReq_1    <= 1'b1;
                     o_MemWe_1     <= isStore;
                     o_MemAddr_32  <= {ea[31:2], 2'b00};
                     o_MemBe_4     <= isStore ? stBe : 4'hF;
                     o_MemWdata_32 <= isStore ? stWdata : 32'h0;
                  end
               end
            end
            REQ: begin
               cnt <= cnt + 16'd1;
               if (i_MemGnt_1) begin
                  state      <= WAIT;
                  o_MemReq_1 <= 1'b0;
               end else if (tmo) begin
                  state                <= WB;
                  o_MemReq_1           <= 1'b0;
                  o_DriveToWriteBack_1 <= 1'b1;
                  o_WbWe_1             <= 1'b0;
                  o_WbData_32          <= addr;
                  o_WbExc_2            <= 2'b11;
               end
            end
            WAIT: begin
               cnt <= cnt + 16'd1;
               if (i_MemRvalid_1) begin
                  state                <= WB;
                  o_DriveToWriteBack_1 <= 1'b1;
                  o_WbWe_1             <= ~op[3];
                  o_WbData_32          <= op[3] ? 32'h0 : ldData;
                  o_WbExc_2            <= 2'b00;
               end else if (tmo) begin
                  state                <= WB;
                  o_DriveToWriteBack_1 <= 1'b1;
                  o_WbWe_1             <= 1'b0;
                  o_WbData_32          <= addr;
                  o_WbExc_2            <= 2'b11;
               end
            end
            WB: begin
               if (i_FreeFromWriteBack_1) begin
                  state                <= IDLE;
                  o_DriveToWriteBack_1 <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_exe.sv
// Bench for lsu_exe: directed vector table, timeout/reset sequences and
// randomized transactions against a byte-level reference model.
module tb_lsu_exe;

   localparam int TAG_W = 4;
   localparam int TMO   = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             drv = 1'b0;
   logic             free;
   logic [3:0]       lsuOp = '0;
   logic [4:0]       rd = '0;
   logic [TAG_W-1:0] tag = '0;
   logic [31:0]      opL = '0;
   logic [31:0]      opR = '0;
   logic [31:0]      imm = '0;
   logic             memReq;
   logic             memWe;
   logic [31:0]      memAddr;
   logic [3:0]       memBe;
   logic [31:0]      memWdata;
   logic             gnt = 1'b0;
   logic             rvalid = 1'b0;
   logic [31:0]      rdata = '0;
   logic             wbDrive;
   logic             wbFree = 1'b0;
   logic [4:0]       wbRd;
   logic             wbWe;
   logic [31:0]      wbData;
   logic [TAG_W-1:0] wbTag;
   logic [1:0]       wbExc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_exe #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .i_DriveFromIssue_1    (drv),
      .o_FreeToIssue_1       (free),
      .i_LsuOp_4             (lsuOp),
      .i_Rd_5                (rd),
      .i_Tag_TAG_W           (tag),
      .i_OperandL_32         (opL),
      .i_OperandR_32         (opR),
      .i_Imm_32              (imm),
      .o_MemReq_1            (memReq),
      .o_MemWe_1             (memWe),
      .o_MemAddr_32          (memAddr),
      .o_MemBe_4             (memBe),
      .o_MemWdata_32         (memWdata),
      .i_MemGnt_1            (gnt),
      .i_MemRvalid_1         (rvalid),
      .i_MemRdata_32         (rdata),
      .o_DriveToWriteBack_1  (wbDrive),
      .i_FreeFromWriteBack_1 (wbFree),
      .o_WbRd_5              (wbRd),
      .o_WbWe_1              (wbWe),
      .o_WbData_32           (wbData),
      .o_WbTag_TAG_W         (wbTag),
      .o_WbExc_2             (wbExc)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] opL;
      logic [31:0] imm;
      logic [31:0] rs2;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic [3:0]  tag;
      int          gD;
      int          rD;
      int          fD;
      logic        misal;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] wbData;
      logic        wbWe;
      logic [1:0]  exc;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] l,
                               input logic [31:0] im, input logic [31:0] r2,
                               input logic [31:0] rdt, input int gD,
                               input int rD, input int fD, input logic mis,
                               input logic [31:0] ma, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] wbd,
                               input logic we, input logic [1:0] exc);
      vec_t v;
      v.op = op; v.opL = l; v.imm = im; v.rs2 = r2; v.rdata = rdt;
      v.rd = 5'($urandom); v.tag = 4'($urandom);
      v.gD = gD; v.rD = rD; v.fD = fD;
      v.misal = mis; v.maddr = ma; v.be = be; v.wdata = wd;
      v.wbData = wbd; v.wbWe = we; v.exc = exc;
      return v;
   endfunction

   // Reference: works in bytes and lane indices rather than shift masks
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      logic [31:0] a;
      logic [31:0] val;
      int          nb;
      int          off;
      int          beI;
      r = v;
      a = v.opL + v.imm;
      off = int'(a[1:0]);
      nb = (v.op[1:0] == 2'b00) ? 1 : (v.op[1:0] == 2'b01) ? 2 : 4;
      r.misal = (a % nb) != 0;
      r.maddr = a - (a % 4);
      r.be = 4'hF; r.wdata = '0; r.wbData = '0; r.wbWe = 1'b0; r.exc = 2'b00;
      if (r.misal) begin
         r.exc = v.op[3] ? 2'b10 : 2'b01;
         r.wbData = a;
      end else if (v.op[3]) begin
         beI = ((1 << nb) - 1) << off;
         r.be = beI[3:0];
         for (int i = 0; i < 4; i++)
            r.wdata[8*i +: 8] = v.rs2[8*(i % nb) +: 8];
      end else begin
         val = '0;
         for (int i = 0; i < nb; i++)
            val[8*i +: 8] = v.rdata[8*(off+i) +: 8];
         if (!v.op[2] && nb < 4 && val[8*nb-1])
            for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
         r.wbData = val;
         r.wbWe = 1'b1;
      end
      return r;
   endfunction

   task automatic doTxn(input string nm, input vec_t v);
      chk($sformatf("%s free-idle", nm), free, 1);
      drv = 1'b1; lsuOp = v.op; opL = v.opL; imm = v.imm; opR = v.rs2;
      rd = v.rd; tag = v.tag;
      step();
      drv = 1'b0; opL = $urandom; imm = $urandom; opR = $urandom;
      rd = 5'($urandom); tag = 4'($urandom); lsuOp = 4'($urandom);
      if (v.misal) begin
         chk($sformatf("%s no-req", nm), memReq, 0);
      end else begin
         for (int k = 0; k <= v.gD; k++) begin
            chk($sformatf("%s req", nm), memReq, 1);
            chk($sformatf("%s addr", nm), memAddr, v.maddr);
            chk($sformatf("%s be", nm), memBe, v.be);
            chk($sformatf("%s we", nm), memWe, v.op[3]);
            if (v.op[3]) chk($sformatf("%s wdata", nm), memWdata, v.wdata);
            chk($sformatf("%s free-req", nm), free, 0);
            chk($sformatf("%s drive-req", nm), wbDrive, 0);
            gnt = (k == v.gD);
            step();
         end
         gnt = 1'b0;
         chk($sformatf("%s req-drop", nm), memReq, 0);
         for (int k = 1; k <= v.rD; k++) begin
            chk($sformatf("%s drive-wait", nm), wbDrive, 0);
            rvalid = (k == v.rD);
            rdata = (k == v.rD) ? v.rdata : $urandom;
            step();
         end
         rvalid = 1'b0;
         rdata = $urandom;
      end
      for (int k = 0; k <= v.fD; k++) begin
         chk($sformatf("%s drive", nm), wbDrive, 1);
         chk($sformatf("%s wbRd", nm), wbRd, v.rd);
         chk($sformatf("%s wbTag", nm), wbTag, v.tag);
         chk($sformatf("%s wbWe", nm), wbWe, v.wbWe);
         chk($sformatf("%s wbData", nm), wbData, v.wbData);
         chk($sformatf("%s wbExc", nm), wbExc, v.exc);
         chk($sformatf("%s free-wb", nm), free, 0);
         wbFree = (k == v.fD);
         step();
      end
      wbFree = 1'b0;
      chk($sformatf("%s drive-off", nm), wbDrive, 0);
   endtask

   task automatic chkZero(input string nm);
      chk({nm, " req"}, memReq, 0);
      chk({nm, " memWe"}, memWe, 0);
      chk({nm, " addr"}, memAddr, 0);
      chk({nm, " be"}, memBe, 0);
      chk({nm, " wdata"}, memWdata, 0);
      chk({nm, " drive"}, wbDrive, 0);
      chk({nm, " wbRd"}, wbRd, 0);
      chk({nm, " wbWe"}, wbWe, 0);
      chk({nm, " wbData"}, wbData, 0);
      chk({nm, " wbTag"}, wbTag, 0);
      chk({nm, " wbExc"}, wbExc, 0);
      chk({nm, " free"}, free, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[13];
      vec_t v;
      int   n;

      tbl[0]  = mk(4'b0000, 32'h1000, 3, 0, 32'h80FF_1234, 0, 1, 0,
                   0, 32'h1000, 4'hF, 0, 32'hFFFF_FF80, 1, 2'b00);
      tbl[1]  = mk(4'b1001, 32'h2002, 0, 32'hDEAD_BEEF, 0, 0, 1, 0,
                   0, 32'h2000, 4'hC, 32'hBEEF_BEEF, 0, 0, 2'b00);
      tbl[2]  = mk(4'b0010, 32'h3000, 1, 0, 0, 0, 1, 0,
                   1, 0, 4'hF, 0, 32'h0000_3001, 0, 2'b01);
      tbl[3]  = mk(4'b0101, 32'h5000, 2, 0, 32'h9ABC_0000, 0, 1, 0,
                   0, 32'h5000, 4'hF, 0, 32'h0000_9ABC, 1, 2'b00);
      tbl[4]  = mk(4'b1000, 32'h10, 1, 32'h1234_56A5, 0, 1, 2, 1,
                   0, 32'h10, 4'h2, 32'hA5A5_A5A5, 0, 0, 2'b00);
      tbl[5]  = mk(4'b1010, 32'h20, 32'hFFFF_FFFE, 0, 0, 0, 1, 0,
                   1, 0, 4'hF, 0, 32'h1E, 0, 2'b10);
      tbl[6]  = mk(4'b0001, 32'h100, 0, 0, 32'h1234_8001, 0, 1, 5,
                   0, 32'h100, 4'hF, 0, 32'hFFFF_8001, 1, 2'b00);
      tbl[7]  = mk(4'b0011, 32'hFFFF_FFF0, 32'h14, 0, 32'hCAFE_F00D, 2, 2, 0,
                   0, 32'h4, 4'hF, 0, 32'hCAFE_F00D, 1, 2'b00);
      tbl[8]  = mk(4'b0100, 32'h7, 0, 0, 32'h8899_AABB, 0, 1, 0,
                   0, 32'h4, 4'hF, 0, 32'h88, 1, 2'b00);
      tbl[9]  = mk(4'b1010, 32'h40, 4, 32'h0102_0304, 0, 0, 2, 0,
                   0, 32'h44, 4'hF, 32'h0102_0304, 0, 0, 2'b00);
      tbl[10] = mk(4'b0001, 32'h31, 0, 0, 0, 0, 1, 0,
                   1, 0, 4'hF, 0, 32'h31, 0, 2'b01);
      tbl[11] = mk(4'b0010, 32'h8000, 0, 0, 32'h5555_AAAA, 7, 1, 0,
                   0, 32'h8000, 4'hF, 0, 32'h5555_AAAA, 1, 2'b00);
      tbl[12] = mk(4'b1100, 32'h103, 0, 32'h0000_0077, 0, 1, 1, 2,
                   0, 32'h100, 4'h8, 32'h7777_7777, 0, 0, 2'b00);

      rst = 1'b1;
      step();
      step();
      chkZero("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 13; i++)
         doTxn($sformatf("vec%0d", i), tbl[i]);

      // bus timeout with gnt held low, then a stray late rvalid
      chk("tmo free", free, 1);
      drv = 1'b1; lsuOp = 4'b0010; opL = 32'h4000; imm = 0;
      rd = 5'd9; tag = 4'd3;
      step();
      drv = 1'b0;
      n = 0;
      while (memReq && n < 20) begin
         n++;
         step();
      end
      chk("tmo req-cycles", n, TMO);
      chk("tmo drive", wbDrive, 1);
      chk("tmo exc", wbExc, 2'b11);
      chk("tmo data", wbData, 32'h4000);
      chk("tmo we", wbWe, 0);
      chk("tmo rd", wbRd, 5'd9);
      rvalid = 1'b1; rdata = 32'h1111_2222;
      step();
      rvalid = 1'b0;
      chk("tmo hold-drive", wbDrive, 1);
      chk("tmo hold-exc", wbExc, 2'b11);
      wbFree = 1'b1;
      step();
      wbFree = 1'b0;
      rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("tmo late-rvalid drive", wbDrive, 0);
         chk("tmo late-rvalid free", free, 1);
         step();
      end

      // reset pulse while waiting for load data
      drv = 1'b1; lsuOp = 4'b0010; opL = 32'h6000; imm = 0;
      rd = 5'd4; tag = 4'd7;
      step();
      drv = 1'b0; gnt = 1'b1;
      step();
      gnt = 1'b0;
      chk("rstw in-wait req", memReq, 0);
      rst = 1'b1;
      step();
      chkZero("rstw");
      rst = 1'b0; rvalid = 1'b1; rdata = 32'hABCD_EF01;
      step();
      rvalid = 1'b0;
      chk("rstw ignore drive", wbDrive, 0);
      chk("rstw idle free", free, 1);
      step();
      chk("rstw ignore drive2", wbDrive, 0);

      for (int i = 0; i < 40; i++) begin
         v.op = 4'($urandom);
         v.opL = $urandom;
         v.imm = $urandom;
         v.rs2 = $urandom;
         v.rdata = $urandom;
         v.rd = 5'($urandom);
         v.tag = 4'($urandom);
         v.gD = $urandom_range(0, 2);
         v.rD = $urandom_range(1, 2);
         v.fD = $urandom_range(0, 2);
         doTxn($sformatf("rnd%0d", i), model(v));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
